// File: rtl/sm2_pkg.sv
// Shared SM2 constants and the modular-exponentiation FSM encoding.
package sm2_pkg;

  localparam int SM2_W     = 256;
  localparam int SM2_CNT_W = 9;

  localparam logic [SM2_W-1:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  // Fermat inversion exponent: x^(p-2) == x^-1 mod p
  localparam logic [SM2_W-1:0] SM2_P_MINUS_2 = SM2_P - 256'd2;

  typedef enum logic [2:0] {
    EXP_IDLE     = 3'd0,
    EXP_SCAN     = 3'd1,
    EXP_SQR_REQ  = 3'd2,
    EXP_SQR_WAIT = 3'd3,
    EXP_MUL_REQ  = 3'd4,
    EXP_MUL_WAIT = 3'd5,
    EXP_DONE     = 3'd6
  } exp_state_e;

endpackage

// File: rtl/mod_exp_seq.sv
// Left-to-right square-and-multiply exponentiation driving an external
// modular multiplier, one request outstanding at a time.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | waiting for exp_vld_i
//  SCAN     | skipping leading zero exponent bits; first 1 loads acc=base
//  SQR_REQ  | issue acc*acc
//  SQR_WAIT | wait for square; next bit decides multiply or continue
//  MUL_REQ  | issue acc*base
//  MUL_WAIT | wait for multiply; bit consumed
//  DONE     | publish result, fin pulse follows
module mod_exp_seq
  import sm2_pkg::*;
#(
  parameter int W     = SM2_W,
  parameter int CNT_W = SM2_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         exp_vld_i,
  input  logic [W-1:0] exp_base_i,
  input  logic [W-1:0] exp_e_i,
  output logic         exp_busy_o,
  output logic         exp_fin_o,
  output logic [W-1:0] exp_r_o,
  output logic         mul_vld_o,
  output logic [W-1:0] mul_a_o,
  output logic [W-1:0] mul_b_o,
  input  logic         mul_fin_i,
  input  logic [W-1:0] mul_r_i
);

  localparam logic [W-1:0]     ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(W);

  exp_state_e       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     base_q, base_d;
  logic [W-1:0]     e_q, e_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     r_q, r_d;
  logic             fin_q, fin_d;

  logic [CNT_W-1:0] cnt_dec;
  logic             last_bit;

  assign cnt_dec  = cnt_q - CNT_W'(1);
  assign last_bit = (cnt_dec == '0);

  // State and datapath registers; reset aborts any run without a fin pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EXP_IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state, exponent-bit consumption and multiplier request strobe.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    base_d    = base_q;
    e_d       = e_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    fin_d     = 1'b0;
    mul_vld_o = 1'b0;
    unique case (state_q)
      EXP_IDLE: begin
        if (exp_vld_i) begin
          base_d = exp_base_i;
          e_d    = exp_e_i;
          cnt_d  = CNT_TOP;
          if (exp_e_i == '0) begin
            acc_d   = ONE;
            state_d = EXP_DONE;
          end else begin
            state_d = EXP_SCAN;
          end
        end
      end
      EXP_SCAN: begin
        e_d   = e_q << 1;
        cnt_d = cnt_dec;
        if (e_q[W-1]) begin
          acc_d   = base_q;
          state_d = last_bit ? EXP_DONE : EXP_SQR_REQ;
        end
      end
      EXP_SQR_REQ: begin
        mul_vld_o = 1'b1;
        state_d   = EXP_SQR_WAIT;
      end
      EXP_SQR_WAIT: begin
        if (mul_fin_i) begin
          acc_d = mul_r_i;
          // a set bit is consumed only after its multiply completes
          if (e_q[W-1]) begin
            state_d = EXP_MUL_REQ;
          end else begin
            e_d     = e_q << 1;
            cnt_d   = cnt_dec;
            state_d = last_bit ? EXP_DONE : EXP_SQR_REQ;
          end
        end
      end
      EXP_MUL_REQ: begin
        mul_vld_o = 1'b1;
        state_d   = EXP_MUL_WAIT;
      end
      EXP_MUL_WAIT: begin
        if (mul_fin_i) begin
          acc_d   = mul_r_i;
          e_d     = e_q << 1;
          cnt_d   = cnt_dec;
          state_d = last_bit ? EXP_DONE : EXP_SQR_REQ;
        end
      end
      EXP_DONE: begin
        r_d     = acc_q;
        fin_d   = 1'b1;
        state_d = EXP_IDLE;
      end
      default: state_d = EXP_IDLE;
    endcase
  end

  // Operands are driven only while a request is in flight, zero otherwise.
  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    unique case (state_q)
      EXP_SQR_REQ, EXP_SQR_WAIT: begin
        mul_a_o = acc_q;
        mul_b_o = acc_q;
      end
      EXP_MUL_REQ, EXP_MUL_WAIT: begin
        mul_a_o = acc_q;
        mul_b_o = base_q;
      end
      default: begin
        mul_a_o = '0;
        mul_b_o = '0;
      end
    endcase
  end

  // fin is registered, so busy must also cover the IDLE cycle carrying it.
  assign exp_busy_o = (state_q != EXP_IDLE) || fin_q;
  assign exp_fin_o  = fin_q;
  assign exp_r_o    = r_q;

endmodule
